// File: rtl/food_ctrl.sv
// Food placement sequencer: detects eating, keeps the score and searches for a
// food position that does not overlap the snake body before committing it.
module food_ctrl #(
  parameter int SEG_AW    = 5,
  parameter int SCORE_W   = 8,
  parameter int MAX_TRIES = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_tick,
  input  logic [7:0]         head_X,
  input  logic [7:0]         head_Y,
  input  logic [7:0]         food_X,
  input  logic [7:0]         food_Y,
  input  logic [7:0]         cand_X,
  input  logic [7:0]         cand_Y,
  input  logic [SEG_AW:0]    snake_len,
  output logic [SEG_AW-1:0]  seg_addr,
  input  logic [7:0]         seg_X,
  input  logic [7:0]         seg_Y,
  input  logic               game_over,
  output logic               grow,
  output logic               gen_food,
  output logic [7:0]         food_new_X,
  output logic [7:0]         food_new_Y,
  output logic               place_fail,
  output logic               busy,
  output logic [SCORE_W-1:0] score
);

  localparam int TRIES_W = ($clog2(MAX_TRIES + 1) > 4) ? $clog2(MAX_TRIES + 1) : 4;
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);

  typedef enum logic [1:0] {IDLE, CAPTURE, SCAN, COMMIT} state_t;

  state_t             state, state_n;
  logic [TRIES_W-1:0] tries, tries_n;
  logic [SEG_AW:0]    j, j_n, len_r, len_n;
  logic [7:0]         cap_X, cap_Y, cap_X_n, cap_Y_n;
  logic [SEG_AW-1:0]  seg_addr_n;
  logic [SCORE_W-1:0] score_n;
  logic [7:0]         food_new_X_n, food_new_Y_n;
  logic               grow_n, gen_food_n, place_fail_n, busy_n;
  logic               eat, cand_ok, seg_hit;

  assign eat     = move_tick && !game_over && (head_X == food_X) && (head_Y == food_Y);
  assign cand_ok = (cand_X >= 8'h11) && (cand_X <= 8'h89) &&
                   (cand_Y >= 8'h0B) && (cand_Y <= 8'h6D);
  // Read data is one cycle behind the address, so the first scan cycle has nothing to compare.
  assign seg_hit = (j != '0) && (seg_X == cap_X) && (seg_Y == cap_Y);

  always_comb begin
    state_n      = state;
    tries_n      = tries;
    j_n          = j;
    len_n        = len_r;
    cap_X_n      = cap_X;
    cap_Y_n      = cap_Y;
    seg_addr_n   = seg_addr;
    score_n      = score;
    busy_n       = busy;
    food_new_X_n = food_new_X;
    food_new_Y_n = food_new_Y;
    grow_n       = 1'b0;
    gen_food_n   = 1'b0;
    place_fail_n = 1'b0;
    case (state)
      IDLE: begin
        if (eat) begin
          grow_n  = 1'b1;
          score_n = (score == '1) ? score : score + 1'b1;
          tries_n = '0;
          busy_n  = 1'b1;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (game_over) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (cand_ok) begin
          cap_X_n    = cand_X;
          cap_Y_n    = cand_Y;
          len_n      = (snake_len == '0) ? (SEG_AW+1)'(1) : snake_len;
          seg_addr_n = '0;
          j_n        = '0;
          tries_n    = tries + 1'b1;
          state_n    = SCAN;
        end
      end
      SCAN: begin
        // A move rewrites the body under the scan, so the attempt is discarded uncounted.
        if (game_over) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (move_tick) begin
          tries_n = tries - 1'b1;
          state_n = CAPTURE;
        end else if (seg_hit && (tries < TRIES_MAX)) begin
          state_n = CAPTURE;
        end else if (seg_hit || (j == len_r)) begin
          gen_food_n   = 1'b1;
          place_fail_n = seg_hit;
          food_new_X_n = cap_X;
          food_new_Y_n = cap_Y;
          state_n      = COMMIT;
        end else begin
          j_n = j + 1'b1;
          if ({1'b0, seg_addr} != (len_r - 1'b1))
            seg_addr_n = seg_addr + 1'b1;
        end
      end
      COMMIT: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tries      <= '0;
      j          <= '0;
      len_r      <= (SEG_AW+1)'(1);
      cap_X      <= '0;
      cap_Y      <= '0;
      seg_addr   <= '0;
      score      <= '0;
      busy       <= 1'b0;
      grow       <= 1'b0;
      gen_food   <= 1'b0;
      place_fail <= 1'b0;
      food_new_X <= 8'h50;
      food_new_Y <= 8'h47;
    end else begin
      tries      <= tries_n;
      j          <= j_n;
      len_r      <= len_n;
      cap_X      <= cap_X_n;
      cap_Y      <= cap_Y_n;
      seg_addr   <= seg_addr_n;
      score      <= score_n;
      busy       <= busy_n;
      grow       <= grow_n;
      gen_food   <= gen_food_n;
      place_fail <= place_fail_n;
      food_new_X <= food_new_X_n;
      food_new_Y <= food_new_Y_n;
    end
  end

endmodule

// File: tb/tb_food_ctrl.sv
// Bench for food_ctrl: directed placement scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the placement search.
module tb_food_ctrl;
  localparam int SEG_AW    = 5;
  localparam int SCORE_W   = 8;
  localparam int MAX_TRIES = 15;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic clk, rst, move_tick, game_over;
  logic [7:0] head_X, head_Y, food_X, food_Y, cand_X, cand_Y, seg_X, seg_Y;
  logic [SEG_AW:0] snake_len;
  logic [SEG_AW-1:0] seg_addr, seg_addr2;
  logic grow, gen_food, place_fail, busy, grow2, gen_food2, place_fail2, busy2;
  logic [7:0] food_new_X, food_new_Y, food_new_X2, food_new_Y2;
  logic [SCORE_W-1:0] score;
  logic [1:0] score2;

  food_ctrl #(.SEG_AW(SEG_AW), .SCORE_W(SCORE_W), .MAX_TRIES(MAX_TRIES)) u_dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .head_X(head_X), .head_Y(head_Y),
    .food_X(food_X), .food_Y(food_Y), .cand_X(cand_X), .cand_Y(cand_Y),
    .snake_len(snake_len), .seg_addr(seg_addr), .seg_X(seg_X), .seg_Y(seg_Y),
    .game_over(game_over), .grow(grow), .gen_food(gen_food), .food_new_X(food_new_X),
    .food_new_Y(food_new_Y), .place_fail(place_fail), .busy(busy), .score(score));

  food_ctrl #(.SEG_AW(SEG_AW), .SCORE_W(2), .MAX_TRIES(MAX_TRIES)) u_dut_sat (
    .clk(clk), .rst(rst), .move_tick(move_tick), .head_X(head_X), .head_Y(head_Y),
    .food_X(food_X), .food_Y(food_Y), .cand_X(cand_X), .cand_Y(cand_Y),
    .snake_len(snake_len), .seg_addr(seg_addr2), .seg_X(seg_X), .seg_Y(seg_Y),
    .game_over(game_over), .grow(grow2), .gen_food(gen_food2), .food_new_X(food_new_X2),
    .food_new_Y(food_new_Y2), .place_fail(place_fail2), .busy(busy2), .score(score2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] body_X [32];
  logic [7:0] body_Y [32];
  logic [7:0] edge_X [4] = '{8'h10, 8'h11, 8'h89, 8'h8A};
  logic [7:0] edge_Y [4] = '{8'h0A, 8'h0B, 8'h6D, 8'h6E};
  int prev_addr, go_cnt, pass_cnt, total_cnt;

  // Model: placement phase plus the precomputed outcome of the current scan.
  typedef enum int {M_IDLE, M_CAPTURE, M_SCAN, M_COMMIT} mphase_t;
  mphase_t m_mode;
  int m_tries, m_len, m_left, m_j;
  bit m_hit;
  logic [7:0] m_capX, m_capY;
  logic e_grow, e_gen, e_fail, e_busy;
  int e_score, e_score2, e_addr;
  logic [7:0] e_fnX, e_fnY;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit in_field(input logic [7:0] x, input logic [7:0] y);
    return (x >= 8'h11) && (x <= 8'h89) && (y >= 8'h0B) && (y <= 8'h6D);
  endfunction

  task automatic modelReset();
    m_mode = M_IDLE; m_tries = 0; m_len = 1; m_left = 0; m_j = 0; m_hit = 0;
    e_grow = 0; e_gen = 0; e_fail = 0; e_busy = 0;
    e_score = 0; e_score2 = 0; e_addr = 0; e_fnX = 8'h50; e_fnY = 8'h47;
  endtask

  task automatic modelCommit(input bit failed);
    e_gen = 1; e_fail = failed; e_fnX = m_capX; e_fnY = m_capY; m_mode = M_COMMIT;
  endtask

  task automatic modelStep();
    int k;
    e_grow = 0; e_gen = 0; e_fail = 0;
    case (m_mode)
      M_IDLE:
        if (move_tick && !game_over && head_X == food_X && head_Y == food_Y) begin
          e_grow = 1; e_busy = 1; m_tries = 0; m_mode = M_CAPTURE;
          if (e_score < SCORE_MAX) e_score++;
          if (e_score2 < 3) e_score2++;
        end
      M_CAPTURE:
        if (game_over) begin
          e_busy = 0; m_mode = M_IDLE;
        end else if (in_field(cand_X, cand_Y)) begin
          m_capX = cand_X; m_capY = cand_Y; m_tries++;
          m_len = (snake_len == 0) ? 1 : int'(snake_len);
          k = -1;
          for (int i = m_len - 1; i >= 0; i--)
            if (body_X[i] == m_capX && body_Y[i] == m_capY) k = i;
          m_hit  = (k >= 0);
          m_left = m_hit ? k + 2 : m_len + 1;
          m_j = 0; e_addr = 0; m_mode = M_SCAN;
        end
      M_SCAN:
        if (game_over) begin
          e_busy = 0; m_mode = M_IDLE;
        end else if (move_tick) begin
          m_tries--; m_mode = M_CAPTURE;
        end else if (m_left == 1) begin
          if (!m_hit) modelCommit(0);
          else if (m_tries == MAX_TRIES) modelCommit(1);
          else m_mode = M_CAPTURE;
        end else begin
          m_left--; m_j++;
          e_addr = (m_j < m_len) ? m_j : m_len - 1;
        end
      M_COMMIT: begin
        e_busy = 0; m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic checkOutput();
    chk("grow", grow, e_grow);
    chk("gen_food", gen_food, e_gen);
    chk("place_fail", place_fail, e_fail);
    chk("busy", busy, e_busy);
    chk("score", score, e_score);
    chk("seg_addr", seg_addr, e_addr);
    chk("food_new_X", food_new_X, e_fnX);
    chk("food_new_Y", food_new_Y, e_fnY);
    chk("score_sat", score2, e_score2);
  endtask

  // Inputs for the coming edge are already set; step model, move to next cycle, check.
  task automatic advance();
    modelStep();
    @(negedge clk);
    checkOutput();
    seg_X = body_X[prev_addr];
    seg_Y = body_Y[prev_addr];
    prev_addr = int'(seg_addr);
    if (gen_food) begin
      food_X = food_new_X; food_Y = food_new_Y;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    chk("rst_grow", grow, 0);
    chk("rst_gen_food", gen_food, 0);
    chk("rst_place_fail", place_fail, 0);
    chk("rst_busy", busy, 0);
    chk("rst_score", score, 0);
    chk("rst_score_sat", score2, 0);
    chk("rst_seg_addr", seg_addr, 0);
    chk("rst_food_new_X", food_new_X, 8'h50);
    chk("rst_food_new_Y", food_new_Y, 8'h47);
    @(negedge clk);
    rst = 1'b0; move_tick = 0; game_over = 0; go_cnt = 0;
    food_X = 8'h50; food_Y = 8'h47; prev_addr = 0;
    seg_X = body_X[0]; seg_Y = body_Y[0];
    modelReset();
  endtask

  task automatic eatRun(input logic [7:0] c1x, input logic [7:0] c1y,
                        input logic [7:0] c2x, input logic [7:0] c2y, input int limit,
                        output int gen_at, output logic grow1, output logic fail_at,
                        output logic [7:0] fx, output logic [7:0] fy, output logic busy_after);
    head_X = food_X; head_Y = food_Y; move_tick = 1; cand_X = c1x; cand_Y = c1y;
    advance();
    grow1 = grow; move_tick = 0;
    gen_at = -1; fail_at = 0; fx = 0; fy = 0; busy_after = 1;
    for (int i = 2; i <= limit; i++) begin
      advance();
      if (i == 2) begin cand_X = c2x; cand_Y = c2y; end
      if (gen_at >= 0) begin busy_after = busy; break; end
      if (gen_food) begin gen_at = i; fail_at = place_fail; fx = food_new_X; fy = food_new_Y; end
    end
  endtask

  task automatic applyStimulus();
    int r, l, idx;
    l = (snake_len == 0) ? 1 : int'(snake_len);
    move_tick = ($urandom_range(0, 39) == 0);
    if (move_tick) begin
      if ($urandom_range(0, 1) == 1) begin head_X = food_X; head_Y = food_Y; end
      else begin head_X = 8'($urandom); head_Y = 8'($urandom); end
      idx = $urandom_range(0, 31);
      body_X[idx] = 8'($urandom_range(8'h11, 8'h89));
      body_Y[idx] = 8'($urandom_range(8'h0B, 8'h6D));
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        snake_len = (r == 0) ? 6'd0 : (r == 1) ? 6'd32 : 6'($urandom_range(1, 32));
      end
    end
    if (go_cnt > 0) go_cnt--;
    else if ($urandom_range(0, 99) == 0) go_cnt = $urandom_range(1, 3);
    game_over = (go_cnt > 0);
    r = $urandom_range(0, 7);
    if (r == 0) begin
      cand_X = 8'($urandom); cand_Y = 8'($urandom);
    end else if (r == 1) begin
      cand_X = edge_X[$urandom_range(0, 3)]; cand_Y = edge_Y[$urandom_range(0, 3)];
    end else if (r <= 4) begin
      idx = $urandom_range(0, l - 1);
      cand_X = body_X[idx]; cand_Y = body_Y[idx];
    end else begin
      cand_X = 8'($urandom_range(8'h11, 8'h89)); cand_Y = 8'($urandom_range(8'h0B, 8'h6D));
    end
  endtask

  initial begin
    int gen_at, gens;
    logic g1, fl, ba;
    logic [7:0] fx, fy;
    pass_cnt = 0; total_cnt = 0;
    move_tick = 0; game_over = 0; head_X = 0; head_Y = 0;
    cand_X = 8'h30; cand_Y = 8'h30; snake_len = 6'd3;
    for (int i = 0; i < 32; i++) begin body_X[i] = 8'h00; body_Y[i] = 8'h00; end
    body_X[0] = 8'h20; body_X[1] = 8'h21; body_X[2] = 8'h22;
    body_Y[0] = 8'h20; body_Y[1] = 8'h20; body_Y[2] = 8'h20;
    doReset();

    $display("[TB] plain placement");
    eatRun(8'h30, 8'h30, 8'h30, 8'h30, 20, gen_at, g1, fl, fx, fy, ba);
    chk("A_grow_T1", g1, 1);
    chk("A_gen_at", gen_at, 6);
    chk("A_fail", fl, 0);
    chk("A_food_X", fx, 8'h30);
    chk("A_food_Y", fy, 8'h30);
    chk("A_busy_T7", ba, 0);
    chk("A_score", score, 1);

    $display("[TB] single retry");
    eatRun(8'h22, 8'h20, 8'h40, 8'h40, 30, gen_at, g1, fl, fx, fy, ba);
    chk("B_gen_at", gen_at, 11);
    chk("B_fail", fl, 0);
    chk("B_food_X", fx, 8'h40);

    $display("[TB] exhausted retries");
    eatRun(8'h20, 8'h20, 8'h20, 8'h20, 80, gen_at, g1, fl, fx, fy, ba);
    chk("C_gen_at", gen_at, 46);
    chk("C_fail", fl, 1);
    chk("C_food_X", fx, 8'h20);
    chk("C_busy_after", ba, 0);

    $display("[TB] game over mid-scan");
    head_X = food_X; head_Y = food_Y; move_tick = 1; cand_X = 8'h60; cand_Y = 8'h50;
    advance();
    move_tick = 0;
    advance(); advance();
    game_over = 1;
    advance();
    game_over = 0;
    chk("D_busy", busy, 0);
    chk("D_score", score, 4);
    gens = 0;
    for (int i = 0; i < 10; i++) begin advance(); if (gen_food) gens++; end
    chk("D_no_gen", gens, 0);

    $display("[TB] reset mid-scan");
    head_X = food_X; head_Y = food_Y; move_tick = 1;
    advance();
    move_tick = 0;
    advance(); advance();
    doReset();

    $display("[TB] score saturation and busy eat");
    for (int n = 0; n < 4; n++) begin
      eatRun(8'(8'h31 + n), 8'h31, 8'(8'h31 + n), 8'h31, 20, gen_at, g1, fl, fx, fy, ba);
      chk("F_gen_at", gen_at, 6);
    end
    chk("F_score", score, 4);
    chk("F_score_sat", score2, 3);
    head_X = food_X; head_Y = food_Y; move_tick = 1; cand_X = 8'h60; cand_Y = 8'h60;
    advance();
    advance();
    chk("F_no_second_grow", grow, 0);
    move_tick = 0;
    for (int i = 0; i < 20 && busy; i++) advance();
    chk("F_idle_again", busy, 0);
    chk("F_score_final", score, 5);
    chk("F_score_sat_final", score2, 3);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      advance();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
